// File: rtl/demux_1_4_serial_dispatcher_pkg.sv
// demux_1_4_serial_dispatcher_pkg: shared state encoding and default sizes for the demux feeder
package demux_1_4_serial_dispatcher_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_HOLD_CYCLES = 1;
endpackage

// File: rtl/demux_1_4_serial_dispatcher_bit_hold_timer.sv
// demux_1_4_serial_dispatcher_bit_hold_timer: per-bit hold down-counter with one-cycle expire
module demux_1_4_serial_dispatcher_bit_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] TOP = CW'(HOLD_CYCLES - 1);
  logic [CW-1:0] cnt;
  assign expire = en && cnt == '0;
  // reload at every bit boundary so each bit gets a fresh hold window
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load || expire) cnt <= TOP;
    else if (en) cnt <= cnt - 1'b1;
endmodule

// File: rtl/demux_1_4_serial_dispatcher.sv
// demux_1_4_serial_dispatcher: serializes a word LSB-first with a one-hot lane select for the 1:4 demux
module demux_1_4_serial_dispatcher
  import demux_1_4_serial_dispatcher_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_W-1:0]         i_data,
  input  logic [$clog2(NUM_CH)-1:0] i_ch,
  output logic                      o_a,
  output logic [NUM_CH-1:0]         o_sel_code,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state, state_n;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0] bit_cnt;
  logic err_l, accept, expire, last, ch_ok;
  assign accept = i_valid && state == IDLE;
  assign last = expire && bit_cnt == BW'(DATA_W - 1);
  assign ch_ok = 32'(i_ch) < NUM_CH;
  assign o_ready = state == IDLE;
  assign o_busy = state != IDLE;
  assign o_a = sh[0];
  demux_1_4_serial_dispatcher_bit_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(i_clk),
    .rst(i_rst),
    .load(accept),
    .en(state == SHIFT),
    .expire(expire)
  );
  // state register
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_n;
  // IDLE -> SHIFT on accept, SHIFT -> GAP after the last bit's hold, GAP always returns to IDLE
  always_comb
    state_n = state == IDLE ? (accept ? SHIFT : IDLE) : state == SHIFT ? (last ? GAP : SHIFT) : IDLE;
  // shift register, bit counter and lane select; sh is cleared when the word ends so o_a idles low
  always_ff @(posedge i_clk)
    if (i_rst) begin
      sh <= '0;
      bit_cnt <= '0;
      o_sel_code <= '0;
      err_l <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_done <= last;
      o_err <= last && err_l;
      if (accept) begin
        sh <= i_data;
        o_sel_code <= ch_ok ? NUM_CH'(1) << i_ch : '0;
        err_l <= !ch_ok;
      end else if (last) begin
        sh <= '0;
        bit_cnt <= '0;
        o_sel_code <= '0;
      end else if (expire) begin
        sh <= sh >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_demux_1_4_serial_dispatcher.sv
// tb_demux_1_4_serial_dispatcher: vectors, corner sequences and random words against a timing model
module tb_demux_1_4_serial_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic valid [3];
  logic [7:0] data [3];
  logic [1:0] ch [3];
  logic r [3];
  logic a [3];
  logic b [3];
  logic dn [3];
  logic er [3];
  logic [3:0] s0, s1;
  logic [2:0] s2;
  int checks = 0;
  int errors = 0;

  demux_1_4_serial_dispatcher dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(r[0]), .i_data(data[0]), .i_ch(ch[0]),
    .o_a(a[0]), .o_sel_code(s0), .o_busy(b[0]), .o_done(dn[0]), .o_err(er[0]));
  demux_1_4_serial_dispatcher #(.HOLD_CYCLES(3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(r[1]), .i_data(data[1]), .i_ch(ch[1]),
    .o_a(a[1]), .o_sel_code(s1), .o_busy(b[1]), .o_done(dn[1]), .o_err(er[1]));
  demux_1_4_serial_dispatcher #(.NUM_CH(3)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .o_ready(r[2]), .i_data(data[2]), .i_ch(ch[2]),
    .o_a(a[2]), .o_sel_code(s2), .o_busy(b[2]), .o_done(dn[2]), .o_err(er[2]));

  function automatic logic [3:0] sel_of(int k);
    return k == 0 ? s0 : k == 1 ? s1 : {1'b0, s2};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: bit i of the word sits on o_a for cycles i*hold+1..(i+1)*hold after accept,
  // the lane select is constant across those cycles, and done (with err) follows one cycle later
  task automatic send(int k, logic [7:0] d, logic [1:0] c, logic [3:0] xsel, logic xerr, string nm);
    int hold = k == 1 ? 3 : 1;
    int w = 0;
    valid[k] = 1'b1;
    data[k] = d;
    ch[k] = c;
    @(negedge clk);
    while (!r[k] && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk({nm, "_ready_in"}, 32'(r[k]), 1);
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    data[k] = 8'($urandom);
    ch[k] = 2'($urandom);
    for (int n = 1; n <= 8 * hold + 1; n++) begin
      @(negedge clk);
      chk({nm, "_a"}, 32'(a[k]), n <= 8 * hold ? 32'(d[(n - 1) / hold]) : 0);
      chk({nm, "_sel"}, 32'(sel_of(k)), n <= 8 * hold ? 32'(xsel) : 0);
      chk({nm, "_done"}, 32'(dn[k]), 32'(n == 8 * hold + 1));
      chk({nm, "_err"}, 32'(er[k]), 32'(n == 8 * hold + 1 && xerr));
      chk({nm, "_busy"}, 32'(b[k]), 1);
    end
    @(negedge clk);
    chk({nm, "_ready_out"}, 32'(r[k]), 1);
    chk({nm, "_busy_out"}, 32'(b[k]), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
    int k;
    logic [3:0] sel;
    logic err;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    int n, dones;
    tbl[0] = '{8'hA5, 2'd2, 0, 4'b0100, 1'b0};
    tbl[1] = '{8'h01, 2'd0, 1, 4'b0001, 1'b0};
    tbl[2] = '{8'h3C, 2'd3, 0, 4'b1000, 1'b0};
    tbl[3] = '{8'h96, 2'd3, 2, 4'b0000, 1'b1};
    tbl[4] = '{8'h5B, 2'd1, 2, 4'b0010, 1'b0};
    tbl[5] = '{8'hE7, 2'd2, 1, 4'b0100, 1'b0};
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      data[k] = 8'h00;
      ch[k] = 2'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(r[k]), 1);
      chk("rst_sel", 32'(sel_of(k)), 0);
      chk("rst_a", 32'(a[k]), 0);
      chk("rst_busy", 32'(b[k]), 0);
      chk("rst_done", 32'(dn[k]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++)
      send(tbl[i].k, tbl[i].d, tbl[i].c, tbl[i].sel, tbl[i].err, $sformatf("vec%0d", i));

    // back-to-back: valid stays high across two words
    @(posedge clk);
    #1;
    valid[0] = 1'b1;
    data[0] = 8'hFF;
    ch[0] = 2'd3;
    @(posedge clk);
    #1;
    data[0] = 8'h00;
    ch[0] = 2'd1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 8) chk("b2b_sel_last", 32'(s0), 32'b1000);
      if (n == 9) chk("b2b_sel_gap", 32'(s0), 0);
    end while (!r[0] && n < 40);
    chk("b2b_period", n, 10);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b_sel_second", 32'(s0), 32'b0010);
    chk("b2b_a_second", 32'(a[0]), 0);
    repeat (12) @(negedge clk);
    chk("b2b_idle", 32'(r[0]), 1);

    // busy reject: a second word offered during SHIFT is ignored
    @(posedge clk);
    #1;
    valid[0] = 1'b1;
    data[0] = 8'h5A;
    ch[0] = 2'd1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    dones = 0;
    for (int m = 1; m <= 16; m++) begin
      @(negedge clk);
      if (m == 3) begin
        valid[0] = 1'b1;
        data[0] = 8'h33;
        ch[0] = 2'd0;
      end
      if (m == 4) valid[0] = 1'b0;
      if (m >= 1 && m <= 8) chk("busy_sel", 32'(s0), 32'b0010);
      if (m == 4) chk("busy_ready", 32'(r[0]), 0);
      if (dn[0]) dones++;
    end
    chk("busy_done_count", dones, 1);
    chk("busy_idle", 32'(r[0]), 1);

    // reset mid-word aborts without a done pulse
    @(posedge clk);
    #1;
    valid[0] = 1'b1;
    data[0] = 8'hC3;
    ch[0] = 2'd0;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_bit4", 32'(a[0]), 0);
    chk("mid_sel", 32'(s0), 32'b0001);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", 32'(s0), 0);
    chk("mid_rst_a", 32'(a[0]), 0);
    chk("mid_rst_ready", 32'(r[0]), 1);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[0]) dones++;
    end
    chk("mid_no_done", dones, 0);

    for (int i = 0; i < 24; i++) begin
      int k = $urandom_range(0, 2);
      logic [7:0] d = 8'($urandom);
      logic [1:0] c = 2'($urandom);
      int nch = k == 2 ? 3 : 4;
      send(k, d, c, 32'(c) < nch ? 4'(1) << c : 4'b0, 32'(c) >= nch, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
